// File: rtl/uart_pixel_deframer_pkg.sv
// Shared definitions for the UART pixel deframer: FSM states, FIFO entry layout and header checks.
package uart_pixel_deframer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WH   = 3'd1,
        S_WL   = 3'd2,
        S_HH   = 3'd3,
        S_HL   = 3'd4,
        S_PIX  = 3'd5
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // FIFO entry is {eof, eol, sof, data[7:0]}
    localparam int TAG_SOF = 8;
    localparam int TAG_EOL = 9;
    localparam int TAG_EOF = 10;
    localparam int ENTRY_W = 11;

    function automatic logic dim_ok(input logic [15:0] dim, input logic [15:0] max_dim);
        return (dim != 16'd0) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/uart_pixel_deframer_pix_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty derived from pointers carrying one extra wrap bit.
module uart_pixel_deframer_pix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_en_s;
    logic             rd_en_s;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rd_en_s = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en_s = push && (!full || rd_en_s);
    assign head    = mem_r[rd_ptr_r[AW-1:0]];

    // Storage and pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_pixel_deframer.sv
// Parses SYNC/width/height headers from UART bytes and queues tagged raster pixels for the encoder.
module uart_pixel_deframer
    import uart_pixel_deframer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int         FIFO_DEPTH = 16,
    parameter int         MAX_DIM    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic [15:0] img_width,
    output logic [15:0] img_height,
    output logic        busy,
    output logic        hdr_err,
    output logic        ovf_err
);

    localparam logic [15:0] MAX_DIM_W = MAX_DIM[15:0];

    state_t              state_r;
    logic                busy_r;
    logic                hdr_err_r;
    logic                ovf_err_r;
    logic [15:0]         w_hdr_r;
    logic [7:0]          h_hi_r;
    logic [15:0]         img_width_r;
    logic [15:0]         img_height_r;
    logic [15:0]         col_r;
    logic [15:0]         row_r;

    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic                sof_s;
    logic                eol_s;
    logic                eof_s;
    logic [15:0]         h_full_s;
    logic [ENTRY_W-1:0]  entry_s;
    logic [ENTRY_W-1:0]  head_s;
    logic                empty_s;
    logic                full_s;

    assign h_full_s = {h_hi_r, rx_data};
    assign push_s   = rx_valid && (state_r == S_PIX);
    assign sof_s    = (col_r == 16'd0) && (row_r == 16'd0);
    assign eol_s    = (col_r == img_width_r - 16'd1);
    assign eof_s    = eol_s && (row_r == img_height_r - 16'd1);
    assign entry_s  = {eof_s, eol_s, sof_s, rx_data};
    assign pop_s    = pix_ready && !empty_s;
    assign drop_s   = push_s && full_s && !pop_s;

    uart_pixel_deframer_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    // Header parser, raster counters and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            hdr_err_r    <= 1'b0;
            ovf_err_r    <= 1'b0;
            w_hdr_r      <= 16'd0;
            h_hi_r       <= 8'd0;
            img_width_r  <= 16'd0;
            img_height_r <= 16'd0;
            col_r        <= 16'd0;
            row_r        <= 16'd0;
        end else if (rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_r <= S_WH;
                        busy_r  <= 1'b1;
                    end
                end
                S_WH: begin
                    w_hdr_r[15:8] <= rx_data;
                    state_r       <= S_WL;
                end
                S_WL: begin
                    w_hdr_r[7:0] <= rx_data;
                    state_r      <= S_HH;
                end
                S_HH: begin
                    h_hi_r  <= rx_data;
                    state_r <= S_HL;
                end
                S_HL: begin
                    if (dim_ok(w_hdr_r, MAX_DIM_W) && dim_ok(h_full_s, MAX_DIM_W)) begin
                        img_width_r  <= w_hdr_r;
                        img_height_r <= h_full_s;
                        hdr_err_r    <= 1'b0;
                        ovf_err_r    <= 1'b0;
                        col_r        <= 16'd0;
                        row_r        <= 16'd0;
                        state_r      <= S_PIX;
                    end else begin
                        hdr_err_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                S_PIX: begin
                    // Counters advance even on a dropped byte so row/frame framing survives overflow
                    if (drop_s) begin
                        ovf_err_r <= 1'b1;
                    end
                    if (eol_s) begin
                        col_r <= 16'd0;
                        row_r <= row_r + 16'd1;
                    end else begin
                        col_r <= col_r + 16'd1;
                    end
                    if (eof_s) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pix_valid  = !empty_s;
    assign pix_data   = head_s[7:0];
    assign pix_sof    = !empty_s && head_s[TAG_SOF];
    assign pix_eol    = !empty_s && head_s[TAG_EOL];
    assign pix_eof    = !empty_s && head_s[TAG_EOF];
    assign img_width  = img_width_r;
    assign img_height = img_height_r;
    assign busy       = busy_r;
    assign hdr_err    = hdr_err_r;
    assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_uart_pixel_deframer.sv
// Directed and randomized frames checked against a queue-based model of the expected pixel stream.
module tb_uart_pixel_deframer;

    localparam int DEPTH  = 16;
    localparam int K_NONE = 0;
    localparam int K_PIX  = 1;
    localparam int K_ACC  = 2;
    localparam int K_REJ  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        pix_ready = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        busy;
    logic        hdr_err;
    logic        ovf_err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    logic        m_ovf = 1'b0;
    logic        m_hdr = 1'b0;
    int          rdy_mode = 1;
    logic        stall_now = 1'b0;

    uart_pixel_deframer #(
        .SYNC_BYTE  (8'hA5),
        .FIFO_DEPTH (DEPTH),
        .MAX_DIM    (4096)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .img_width  (img_width),
        .img_height (img_height),
        .busy       (busy),
        .hdr_err    (hdr_err),
        .ovf_err    (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs, drive inputs, then apply the reference FIFO rules at the edge
    task automatic step(input logic v, input logic [7:0] d, input int kind, input logic [10:0] ent);
        logic        rdy;
        logic        pop;
        int          sz;
        logic [10:0] tmp;
        chk("pix_valid", {31'd0, pix_valid}, {31'd0, (exp_q.size() != 0)});
        if (exp_q.size() != 0)
            chk("pix_head", {21'd0, pix_eof, pix_eol, pix_sof, pix_data}, {21'd0, exp_q[0]});
        chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
        chk("hdr_err", {31'd0, hdr_err}, {31'd0, m_hdr});
        if (stall_now) rdy = 1'b0;
        else if (rdy_mode == 2) rdy = ($urandom_range(0, 1) == 1);
        else rdy = (rdy_mode != 0);
        pix_ready = rdy;
        rx_valid  = v;
        rx_data   = d;
        sz  = exp_q.size();
        pop = rdy && (sz > 0);
        @(posedge clk);
        if (pop) tmp = exp_q.pop_front();
        if (v && kind == K_PIX) begin
            if (sz < DEPTH || pop) exp_q.push_back(ent);
            else m_ovf = 1'b1;
        end
        if (v && kind == K_ACC) begin
            m_ovf = 1'b0;
            m_hdr = 1'b0;
        end
        if (v && kind == K_REJ) m_hdr = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic sendb(input logic [7:0] d, input int kind, input logic [10:0] ent, input int gap);
        int n;
        n = (gap > 0) ? $urandom_range(0, gap) : 0;
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, K_NONE, 11'd0);
        step(1'b1, d, kind, ent);
    endtask

    // pmode: 0 -> pixel i is i+1, 1 -> (i+1)*16, 2 -> random; n_send < 0 sends every pixel
    task automatic send_frame(input int w, input int h, input int pmode, input int gap,
                              input int stall_n, input int n_send);
        logic [15:0] ws;
        logic [15:0] hs;
        logic [7:0]  d;
        logic        ok;
        logic        sof;
        logic        eol;
        logic        eof;
        int          idx;
        ws = 16'(w);
        hs = 16'(h);
        ok = (w >= 1) && (w <= 4096) && (h >= 1) && (h <= 4096);
        sendb(8'hA5, K_NONE, 11'd0, gap);
        sendb(ws[15:8], K_NONE, 11'd0, gap);
        sendb(ws[7:0], K_NONE, 11'd0, gap);
        sendb(hs[15:8], K_NONE, 11'd0, gap);
        sendb(hs[7:0], ok ? K_ACC : K_REJ, 11'd0, gap);
        if (!ok) return;
        idx = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n_send >= 0 && idx >= n_send) begin
                    stall_now = 1'b0;
                    return;
                end
                if (pmode == 0) d = 8'(idx + 1);
                else if (pmode == 1) d = 8'((idx + 1) * 16);
                else d = 8'($urandom_range(0, 255));
                sof = (r == 0) && (c == 0);
                eol = (c == w - 1);
                eof = eol && (r == h - 1);
                stall_now = (idx < stall_n);
                sendb(d, K_PIX, {eof, eol, sof, d}, gap);
                idx++;
            end
        end
        stall_now = 1'b0;
    endtask

    task automatic drain();
        rdy_mode = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1'b0, 8'd0, K_NONE, 11'd0);
        chk("drain_valid", {31'd0, pix_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        pix_ready = 1'b0;
        #2;
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_data", {21'd0, pix_eof, pix_eol, pix_sof, pix_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dims", {img_width, img_height}, 32'd0);
        chk("rst_errs", {30'd0, hdr_err, ovf_err}, 32'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        m_hdr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w;
        int h;
        int sel;
        @(negedge clk);
        do_reset();

        // 2x2 frame, consumer always ready
        rdy_mode = 1;
        send_frame(2, 2, 1, 0, 0, -1);
        chk("busy_after_2x2", {31'd0, busy}, 32'd0);
        chk("img_width_2x2", {16'd0, img_width}, 32'd2);
        chk("img_height_2x2", {16'd0, img_height}, 32'd2);
        drain();

        // leading garbage then 3x1 frame
        sendb(8'h00, K_NONE, 11'd0, 0);
        sendb(8'hFF, K_NONE, 11'd0, 0);
        chk("busy_garbage", {31'd0, busy}, 32'd0);
        send_frame(3, 1, 0, 0, 0, -1);
        drain();
        chk("busy_after_3x1", {31'd0, busy}, 32'd0);
        chk("img_width_3x1", {16'd0, img_width}, 32'd3);

        // zero width rejected, dims held; next good frame clears the error
        send_frame(0, 5, 0, 0, 0, -1);
        chk("hdr_err_set", {31'd0, hdr_err}, 32'd1);
        chk("busy_after_rej", {31'd0, busy}, 32'd0);
        chk("img_width_hold", {16'd0, img_width}, 32'd3);
        send_frame(2, 1, 2, 0, 0, -1);
        drain();
        chk("hdr_err_clear", {31'd0, hdr_err}, 32'd0);

        // 20 pixels into a 16-deep FIFO with the consumer stalled
        rdy_mode = 0;
        send_frame(20, 1, 0, 0, 0, -1);
        chk("ovf_err_set", {31'd0, ovf_err}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd0);
        drain();

        // full FIFO with simultaneous push and pop must not drop
        rdy_mode = 1;
        send_frame(18, 1, 0, 0, 16, -1);
        drain();
        chk("ovf_err_simul", {31'd0, ovf_err}, 32'd0);

        // reset in the middle of a frame
        rdy_mode = 0;
        send_frame(2, 2, 1, 0, 0, 2);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_valid", {31'd0, pix_valid}, 32'd1);
        do_reset();
        rdy_mode = 1;
        send_frame(2, 2, 1, 0, 0, -1);
        drain();

        // dimension boundary: 4096 accepted, 4097 rejected
        send_frame(4096, 1, 2, 0, 0, -1);
        chk("img_width_max", {16'd0, img_width}, 32'd4096);
        drain();
        send_frame(4097, 1, 0, 0, 0, -1);
        chk("hdr_err_4097", {31'd0, hdr_err}, 32'd1);
        chk("img_width_keep", {16'd0, img_width}, 32'd4096);

        // randomized back-to-back frames with random consumer stalls
        rdy_mode = 2;
        for (int f = 0; f < 15; f++) begin
            if ($urandom_range(0, 2) == 0) sendb(8'($urandom_range(0, 164)), K_NONE, 11'd0, 1);
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 4);
            sel = $urandom_range(0, 9);
            if (sel == 0) w = 0;
            else if (sel == 1) h = 0;
            else if (sel == 2) w = 4097;
            send_frame(w, h, 2, $urandom_range(0, 2), 0, -1);
            rdy_mode = 2;
        end
        drain();
        chk("busy_end", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
